// File: rtl/sfr_arb_pkg.sv
// Shared types and constants for the SFR round-robin arbiter.
// Used by sfr_rr_arbiter and rr_prio_enc.
package sfr_arb_pkg;

   typedef enum logic {
      ARB_IDLE      = 1'b0,
      ARB_WAIT_RESP = 1'b1
   } arb_state_e;

   localparam logic [31:0] SFR_ARB_ERR_RDATA = 32'hDEADC0DE;
   localparam int          MAX_MASTERS       = 8;

   // Width of a master index; at least one bit.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Timeout counter width, kept within 8..16 bits.
   function automatic int cnt_w(input int t);
      int w;
      w = $clog2(t + 1);
      if (w < 8)
         w = 8;
      if (w > 16)
         w = 16;
      return w;
   endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: first set request at or after ptr.
// Pure combinational; ptr must be below N.
module rr_prio_enc
   import sfr_arb_pkg::*;
#(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx,
   output logic         valid
);

   // Slot visited at a given offset from ptr, wrapping at N.
   function automatic logic [W-1:0] slot(
      input logic [W-1:0] base,
      input int           off
   );
      int s;
      s = int'(base) + off;
      if (s >= N)
         s = s - N;
      return s[W-1:0];
   endfunction

   // Scan from the farthest offset down so the nearest hit wins.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[slot(ptr, i)])
            idx = slot(ptr, i);
      end
   end

   // Any request yields a grant.
   always_comb begin
      valid = |req;
   end

endmodule

// File: rtl/sfr_rr_arbiter.sv
// Round-robin arbiter sharing one SFR slave among split-transaction masters.
// Optional read timeout: define SFR_ARB_TIMEOUT_EN.
module sfr_rr_arbiter
   import sfr_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_MASTERS-1:0]    m_req_i,
   input  logic [NUM_MASTERS-1:0]    m_we_i,
   input  logic [NUM_MASTERS*32-1:0] m_addr_bi,
   input  logic [NUM_MASTERS*4-1:0]  m_be_bi,
   input  logic [NUM_MASTERS*32-1:0] m_wdata_bi,
   output logic [NUM_MASTERS-1:0]    m_ack_o,
   output logic [NUM_MASTERS-1:0]    m_resp_o,
   output logic [NUM_MASTERS*32-1:0] m_rdata_bo,
   output logic                      s_req_o,
   output logic                      s_we_o,
   output logic [31:0]               s_addr_bo,
   output logic [3:0]                s_be_bo,
   output logic [31:0]               s_wdata_bo,
   input  logic                      s_ack_i,
   input  logic                      s_resp_i,
   input  logic [31:0]               s_rdata_bi,
   output logic                      err_o
);

   localparam int IW = idx_w(NUM_MASTERS);

   if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_nm
      $error("sfr_rr_arbiter: NUM_MASTERS out of range");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
      $error("sfr_rr_arbiter: TIMEOUT_CYCLES out of range");
   end

   arb_state_e    state_q;
   arb_state_e    state_d;
   logic [IW-1:0] rr_ptr_q;
   logic [IW-1:0] owner_q;
   logic [IW-1:0] grant;
   logic          grant_vld;
   logic          hs;
   logic          rd_hs;
   logic          resp_fire;
   logic          timeout;
   logic [31:0]   rdata;

   rr_prio_enc #(
      .N (NUM_MASTERS),
      .W (IW)
   ) u_enc (
      .req   (m_req_i),
      .ptr   (rr_ptr_q),
      .idx   (grant),
      .valid (grant_vld)
   );

   // Route the granted master's request fields to the slave.
   always_comb begin
      s_we_o     = 1'b0;
      s_addr_bo  = '0;
      s_be_bo    = '0;
      s_wdata_bo = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (int'(grant) == k) begin
            s_we_o     = m_we_i[k];
            s_addr_bo  = m_addr_bi[32*k +: 32];
            s_be_bo    = m_be_bi[4*k +: 4];
            s_wdata_bo = m_wdata_bi[32*k +: 32];
         end
      end
   end

   assign hs        = s_req_o && s_ack_i;
   assign rd_hs     = hs && !s_we_o;
   assign resp_fire = (state_q == ARB_WAIT_RESP) && (s_resp_i || timeout);

`ifdef SFR_ARB_TIMEOUT_EN
   localparam int CW = cnt_w(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt_q;

   // Count cycles spent waiting for the read response.
   always_ff @(posedge clk_i) begin
      if (!rst_i)
         cnt_q <= '0;
      else if (rd_hs)
         cnt_q <= '0;
      else if (state_q == ARB_WAIT_RESP)
         cnt_q <= cnt_q + 1'b1;
   end

   // A real response in the same cycle beats the timeout.
   assign timeout = (state_q == ARB_WAIT_RESP) && !s_resp_i &&
                    (cnt_q == CW'(TIMEOUT_CYCLES));
   assign rdata   = timeout ? SFR_ARB_ERR_RDATA : s_rdata_bi;
   assign err_o   = timeout;
`else
   assign timeout = 1'b0;
   assign rdata   = s_rdata_bi;
   assign err_o   = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_i)
         state_q <= ARB_IDLE;
      else
         state_q <= state_d;
   end

   // Next state: reads park until their response returns.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_IDLE:
            if (rd_hs)
               state_d = ARB_WAIT_RESP;
         ARB_WAIT_RESP:
            if (resp_fire)
               state_d = ARB_IDLE;
         default:
            state_d = ARB_IDLE;
      endcase
   end

   // Outputs: request/ack only in IDLE, response only to the owner.
   always_comb begin
      s_req_o    = (state_q == ARB_IDLE) && grant_vld;
      m_ack_o    = '0;
      m_resp_o   = '0;
      m_rdata_bo = {NUM_MASTERS{rdata}};
      for (int k = 0; k < NUM_MASTERS; k++) begin
         m_ack_o[k]  = hs && (int'(grant) == k);
         m_resp_o[k] = resp_fire && (int'(owner_q) == k);
      end
   end

   // Rotate priority past the master that just handshaked.
   always_ff @(posedge clk_i) begin
      if (!rst_i)
         rr_ptr_q <= '0;
      else if (hs)
         rr_ptr_q <= (int'(grant) == NUM_MASTERS - 1) ? '0 : grant + IW'(1);
   end

   // Remember who owns the outstanding read.
   always_ff @(posedge clk_i) begin
      if (!rst_i)
         owner_q <= '0;
      else if (rd_hs)
         owner_q <= grant;
   end

endmodule
